// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_pkg
// Description : Shared definitions for the stopwatch button controller:
//               debounce FSM state encoding, default dwell length and a
//               helper that maps a debounce state to its output level.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

  // 20 ms at 100 MHz.
  localparam int DB_TICKS_DEFAULT = 2_000_000;

  // Debounce states. ZERO/WAIT1 report a low level, ONE/WAIT0 a high level,
  // so the level is simply "currently in (or dwelling out of) the high side".
  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } db_state_e;

  function automatic logic db_level(input db_state_e st);
    return (st == ST_ONE) || (st == ST_WAIT0);
  endfunction

endpackage : sw_pkg
`default_nettype wire

// File: rtl/db_fsm.sv
`default_nettype none
// ============================================================================
// Module      : db_fsm
// Description : Two-flop synchronizer followed by a four-state debounce FSM.
//               A level change is accepted only after the synchronized input
//               has been stable for DB_TICKS consecutive cycles. rise_tick is
//               a single-cycle pulse on an accepted low-to-high change.
// Ports       : clk       - system clock, rising edge
//               reset     - synchronous active-high reset
//               sw        - raw asynchronous (bouncing) switch input
//               db        - debounced level
//               rise_tick - one-cycle pulse when a press is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module db_fsm
  import sw_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db,
  output logic rise_tick
);

  // Counter runs DB_TICKS-1 down to 0; guard the width for tiny DB_TICKS.
  localparam int CW = (DB_TICKS > 2) ? $clog2(DB_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_TICKS - 1);

  logic          sync1_q;
  logic          sync2_q;
  db_state_e     state_q;
  db_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          w_cnt_zero;

  // --------------------------------------------------------------------------
  // Synchronizer: nothing downstream ever sees the raw input.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // State and dwell counter registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_cnt_zero = (cnt_q == '0);

  // --------------------------------------------------------------------------
  // Next-state logic. rise_tick is Mealy-style: it is high during the final
  // dwell cycle so that the consumer's register updates on the same edge that
  // moves the FSM into ONE.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rise_tick = 1'b0;

    case (state_q)
      ST_ZERO: begin
        if (sync2_q) begin
          state_d = ST_WAIT1;
          cnt_d   = CNT_LOAD;
        end
      end

      ST_WAIT1: begin
        if (!sync2_q) begin
          // Bounce: abandon the dwell; the next attempt reloads the counter.
          state_d = ST_ZERO;
        end else if (w_cnt_zero) begin
          state_d   = ST_ONE;
          rise_tick = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_ONE: begin
        if (!sync2_q) begin
          state_d = ST_WAIT0;
          cnt_d   = CNT_LOAD;
        end
      end

      ST_WAIT0: begin
        if (sync2_q) begin
          // Release bounce: back to ONE without a second tick.
          state_d = ST_ONE;
        end else if (w_cnt_zero) begin
          state_d = ST_ZERO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  assign db = db_level(state_q);

endmodule : db_fsm
`default_nettype wire

// File: rtl/sw_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sw_btn_ctrl
// Description : Stopwatch push-button front end. Debounces a start/stop
//               button and a clear button; a start press toggles the run
//               level, a clear press emits a one-cycle clear pulse and stops
//               the stopwatch. Clear takes priority over a same-cycle start.
// Ports       : clk       - system clock, rising edge
//               reset     - synchronous active-high reset
//               btn_start - raw start/stop button
//               btn_clear - raw clear button
//               go        - run level (1 = counting)
//               clr       - one-cycle clear pulse
//               start_db  - debounced start button level
//               clear_db  - debounced clear button level
// Revision    : 1.0 - initial release
// ============================================================================
module sw_btn_ctrl
  import sw_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_clear,
  output logic go,
  output logic clr,
  output logic start_db,
  output logic clear_db
);

  logic start_tick;
  logic clear_tick;
  logic go_q;
  logic go_d;
  logic clr_q;
  logic clr_d;

  db_fsm #(
    .DB_TICKS (DB_TICKS)
  ) u_db_start (
    .clk       (clk),
    .reset     (reset),
    .sw        (btn_start),
    .db        (start_db),
    .rise_tick (start_tick)
  );

  db_fsm #(
    .DB_TICKS (DB_TICKS)
  ) u_db_clear (
    .clk       (clk),
    .reset     (reset),
    .sw        (btn_clear),
    .db        (clear_db),
    .rise_tick (clear_tick)
  );

  // Clear dominates: it forces go low and suppresses a coincident toggle.
  always_comb begin
    go_d  = go_q;
    clr_d = clear_tick;
    if (clear_tick) begin
      go_d = 1'b0;
    end else if (start_tick) begin
      go_d = ~go_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      go_q  <= go_d;
      clr_q <= clr_d;
    end
  end

  assign go  = go_q;
  assign clr = clr_q;

endmodule : sw_btn_ctrl
`default_nettype wire

// File: doc/sw_btn_ctrl.md
SW_BTN_CTRL -- requirements
Module: sw_btn_ctrl

Interface
REQ-001 Parameter DB_TICKS, default 2_000_000, is the number of consecutive stable cycles required to accept a level change (20 ms at 100 MHz); legal range is 2 or more.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_start  input  1  raw, asynchronous, bouncing start/stop push-button.
REQ-005 btn_clear  input  1  raw, asynchronous, bouncing clear push-button.
REQ-006 go  output  1  run level for the stopwatch counter; 1 means counting.
REQ-007 clr  output  1  one-cycle clear pulse for the stopwatch counter.
REQ-008 start_db  output  1  debounced level of btn_start, for LED/debug.
REQ-009 clear_db  output  1  debounced level of btn_clear, for LED/debug.

Function
REQ-010 Each raw button shall pass through a two-flop synchronizer before any other logic; this adds 2 cycles of latency.
REQ-011 Each synchronized button shall feed an independent debounce FSM with states ZERO, WAIT1, ONE, WAIT0; ZERO and WAIT1 drive db=0, ONE and WAIT0 drive db=1.
REQ-012 ZERO: sync=1 -> WAIT1 and load the counter with DB_TICKS-1; otherwise remain in ZERO.
REQ-013 WAIT1: sync=0 -> ZERO (bounce rejected); sync=1 with counter=0 -> ONE and assert rise_tick for 1 cycle; sync=1 with counter nonzero -> decrement the counter.
REQ-014 ONE: sync=0 -> WAIT0 and load the counter with DB_TICKS-1; otherwise remain in ONE.
REQ-015 WAIT0: sync=1 -> ONE with no tick; sync=0 with counter=0 -> ZERO; sync=0 with counter nonzero -> decrement the counter.
REQ-016 Counter width shall be $clog2(DB_TICKS), with no wrap beyond 0; a dwell cut short at any count shall restart from DB_TICKS-1 on the next attempt.
REQ-017 The start button's rise_tick shall toggle go; go shall be registered and change on the cycle after the tick.
REQ-018 The clear button's rise_tick shall produce clr=1 for exactly one cycle, on the cycle after the tick, and shall force go to 0 on that same cycle.
REQ-019 If both rise_ticks occur on the same cycle, clear wins: clr=1 and go=0, with no toggle.
REQ-020 Holding a button for any length of time shall generate exactly one tick; release produces no tick.
REQ-021 Total press latency is 2 synchronizer cycles + DB_TICKS + 1 cycles, measured from the raw rising edge to the change in go or clr.

Reset
REQ-022 Reset shall drive: synchronizer flops 0, both FSMs to ZERO, counters 0, go=0, clr=0, start_db=0, clear_db=0.
REQ-023 Reset asserted mid-dwell (WAIT1/WAIT0) shall abort the dwell with no tick; a button still held after reset releases shall require a full DB_TICKS dwell before it registers.

Structure
REQ-024 The debounce FSM state encoding and the DB_TICKS default shall live in a shared package, sw_pkg.
REQ-025 The synchronizer plus debounce FSM shall be one sub-module, db_fsm (ports clk, reset, sw, db, rise_tick), instantiated twice; the go/clr register logic stays in the top level.

Verification (bench uses DB_TICKS=4)
REQ-026 Clean press: btn_start held high for 20 cycles -> go 0->1 exactly 7 cycles after the raw edge, start_db=1, clr stays 0.
REQ-027 Bounce rejection: btn_start pattern 1,1,0,1,1,0 (1 cycle each), then low -> go stays 0 and no tick is generated.
REQ-028 Toggle: two clean presses separated by a 10-cycle release -> go 0->1, then 1->0; a 30-cycle hold produces only one toggle.
REQ-029 Clear while running: go=1, then a clean btn_clear press -> clr=1 for one cycle and go=0 on that same cycle.
REQ-030 Simultaneous: btn_start and btn_clear rise on the same cycle while go=0 -> clr pulses once and go remains 0.
REQ-031 Reset in WAIT1: reset asserted 2 cycles into the dwell, btn_start still held -> no toggle; go rises 7 cycles after reset deasserts.
